// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared definitions for the mult_div sequencer.
//   state_e                : sequencer state encoding
//   OP_MULT / OP_DIV       : opcode values carried on req_op / md_is_div
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit in WAIT cycles
package mult_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // mult_div worst case is 33 cycles; the rest is margin.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear, enable and a terminal flag.
// Ports:
//   i_clock  : clock, rising edge
//   i_reset  : asynchronous active-high reset (count -> 0)
//   i_clr    : synchronous clear, wins over i_en
//   i_en     : count up by one, holding at SatVal
//   o_count  : current count
//   o_term   : high while o_count == TermVal
module sat_counter #(
  parameter int unsigned Width   = 6,
  parameter int unsigned SatVal  = 40,
  parameter int unsigned TermVal = 39
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [Width-1:0] o_count,
  output logic             o_term
);

  logic [Width-1:0] r_count;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != Width'(SatVal))) begin
      r_count <= r_count + Width'(1);
    end
  end

  assign o_count = r_count;
  assign o_term  = (r_count == Width'(TermVal));

endmodule

// File: rtl/mult_div_seq.sv
// mult_div_seq: sequences one multi-cycle mult_div operation on behalf of Control.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   req, req_op   : start request and opcode (0 mult, 1 div), sampled only in IDLE
//   abort         : cancel the in-flight operation (ignored in COMMIT)
//   rd_hilo       : Control is executing mfhi/mflo this cycle
//   md_done       : Done from mult_div
//   md_divby0     : DivBy0 from mult_div (only meaningful for div)
//   md_start      : one-cycle start pulse to mult_div (LAUNCH)
//   md_is_div     : latched opcode presented to mult_div
//   hi_write      : HI write enable (COMMIT)
//   lo_write      : LO write enable (COMMIT)
//   busy          : state != IDLE
//   ack           : one-cycle request-accepted pulse (LAUNCH)
//   stall         : rd_hilo & busy (combinational)
//   div0_excp     : one-cycle divide-by-zero pulse, first IDLE cycle after the event
//   timeout_err   : one-cycle watchdog pulse, first IDLE cycle after expiry
//   last_cycles   : WAIT-cycle count of the last committed operation
// CNT_W must satisfy 2**CNT_W > TIMEOUT_CYCLES.
module mult_div_seq
  import mult_div_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic             req_op,
  input  logic             abort,
  input  logic             rd_hilo,
  input  logic             md_done,
  input  logic             md_divby0,
  output logic             md_start,
  output logic             md_is_div,
  output logic             hi_write,
  output logic             lo_write,
  output logic             busy,
  output logic             ack,
  output logic             stall,
  output logic             div0_excp,
  output logic             timeout_err,
  output logic [CNT_W-1:0] last_cycles
);

  state_e           r_state, w_state_d;
  logic             r_op_q;
  logic             r_div0, r_timeout;
  logic [CNT_W-1:0] r_last;
  logic             w_div0_d, w_timeout_d, w_done_go;
  logic [CNT_W-1:0] w_cnt;
  logic             w_term;

  // Watchdog: cleared in LAUNCH so the first WAIT cycle sees 0.
  sat_counter #(
    .Width  (CNT_W),
    .SatVal (TIMEOUT_CYCLES),
    .TermVal(TIMEOUT_CYCLES - 1)
  ) u_watchdog (
    .i_clock(clock),
    .i_reset(reset),
    .i_clr  (r_state == ST_LAUNCH),
    .i_en   (r_state == ST_WAIT),
    .o_count(w_cnt),
    .o_term (w_term)
  );

  always_comb begin
    w_state_d   = r_state;
    w_div0_d    = 1'b0;
    w_timeout_d = 1'b0;
    w_done_go   = 1'b0;
    case (r_state)
      ST_IDLE:   if (req) w_state_d = ST_LAUNCH;
      ST_LAUNCH: w_state_d = abort ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        // Priority: abort, div-by-zero (div only), done, watchdog.
        if (abort) begin
          w_state_d = ST_IDLE;
        end else if ((r_op_q == OP_DIV) && md_divby0) begin
          w_state_d = ST_IDLE;
          w_div0_d  = 1'b1;
        end else if (md_done) begin
          w_state_d = ST_COMMIT;
          w_done_go = 1'b1;
        end else if (w_term) begin
          w_state_d   = ST_IDLE;
          w_timeout_d = 1'b1;
        end
      end
      ST_COMMIT: w_state_d = ST_IDLE;
      default:   w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op_q    <= OP_MULT;
      r_div0    <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= '0;
    end else begin
      r_state   <= w_state_d;
      r_div0    <= w_div0_d;
      r_timeout <= w_timeout_d;
      if ((r_state == ST_IDLE) && req) r_op_q <= req_op;
      if (w_done_go) r_last <= w_cnt + CNT_W'(1);
    end
  end

  assign md_start    = (r_state == ST_LAUNCH);
  assign ack         = (r_state == ST_LAUNCH);
  assign hi_write    = (r_state == ST_COMMIT);
  assign lo_write    = (r_state == ST_COMMIT);
  assign busy        = (r_state != ST_IDLE);
  assign md_is_div   = (r_op_q == OP_DIV);
  assign div0_excp   = r_div0;
  assign timeout_err = r_timeout;
  assign last_cycles = r_last;
  // HI/LO only become valid on the edge that ends COMMIT, so COMMIT stalls too.
  assign stall       = rd_hilo & busy;

endmodule

// File: tb/tb_mult_div_seq.sv
module tb_mult_div_seq;

  logic       clock = 1'b0;
  logic       reset;
  logic       req, req_op, abort, rd_hilo, md_done, md_divby0;
  logic       md_start, md_is_div, hi_write, lo_write, busy, ack, stall;
  logic       div0_excp, timeout_err;
  logic [5:0] last_cycles;

  mult_div_seq #(
    .TIMEOUT_CYCLES(40),
    .CNT_W         (6)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_op     (req_op),
    .abort      (abort),
    .rd_hilo    (rd_hilo),
    .md_done    (md_done),
    .md_divby0  (md_divby0),
    .md_start   (md_start),
    .md_is_div  (md_is_div),
    .hi_write   (hi_write),
    .lo_write   (lo_write),
    .busy       (busy),
    .ack        (ack),
    .stall      (stall),
    .div0_excp  (div0_excp),
    .timeout_err(timeout_err),
    .last_cycles(last_cycles)
  );

  always #5 clock = ~clock;

  // Event kinds: 1 = HI/LO commit, 2 = div-by-zero, 3 = timeout.
  typedef struct {
    int kind;
    int cyc;
    int last;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] ack_v, start_v, busy_v, stall_v, hi_v;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Cycle c starts at the c-th rising edge of the run; inputs are driven 2 time units
  // after that edge and outputs sampled 4 units after it.
  task automatic run(input logic op, input logic [63:0] req_m, input logic [63:0] done_m,
                     input logic [63:0] dz_m, input logic [63:0] abort_m,
                     input logic [63:0] rdh_m, input int n);
    int   kind;
    exp_t e;
    ack_v = '0; start_v = '0; busy_v = '0; stall_v = '0; hi_v = '0;
    for (int c = 0; c < n; c++) begin
      @(posedge clock);
      #2;
      req       = req_m[c];
      req_op    = op;
      md_done   = done_m[c];
      md_divby0 = dz_m[c];
      abort     = abort_m[c];
      rd_hilo   = rdh_m[c];
      #2;
      ack_v[c]   = ack;
      start_v[c] = md_start;
      busy_v[c]  = busy;
      stall_v[c] = stall;
      hi_v[c]    = hi_write;
      if (lo_write !== hi_write) check("lo_write_eq_hi_write", lo_write, hi_write);
      if (hi_write || div0_excp || timeout_err) begin
        kind = hi_write ? 1 : (div0_excp ? 2 : 3);
        if (sb.size() == 0) begin
          check("unexpected_event", kind, 0);
        end else begin
          e = sb.pop_front();
          check("event_kind", kind, e.kind);
          check("event_cycle", c, e.cyc);
          if (kind == 1) check("last_cycles", last_cycles, e.last);
        end
      end
    end
    @(posedge clock);
    #2;
    req = 0; md_done = 0; md_divby0 = 0; abort = 0; rd_hilo = 0;
    check("missing_events", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    reset = 1; req = 0; req_op = 0; abort = 0; rd_hilo = 0; md_done = 0; md_divby0 = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_start_ack", {md_start, ack}, 2'b00);
    check("rst_writes", {hi_write, lo_write}, 2'b00);
    check("rst_pulses", {div0_excp, timeout_err, stall, md_is_div}, 4'b0000);
    check("rst_last", last_cycles, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;

    // Mult, done at 35: commit at 36, last_cycles 34.
    sb.push_back('{1, 36, 34});
    run(0, rng(0, 0), rng(35, 35), '0, '0, '0, 40);
    check("mult_ack", ack_v, rng(1, 1));
    check("mult_start", start_v, rng(1, 1));
    check("mult_hi", hi_v, rng(36, 36));
    check("mult_busy", busy_v, rng(1, 36));
    check("mult_is_div", md_is_div, 0);

    // Div with divby0 and done together at 5: div0 pulse at 6, no write.
    sb.push_back('{2, 6, 0});
    run(1, rng(0, 0), rng(5, 5), rng(5, 5), '0, '0, 12);
    check("div0_hi", hi_v, 0);
    check("div0_busy", busy_v, rng(1, 5));
    check("div0_is_div", md_is_div, 1);
    check("div0_last_kept", last_cycles, 34);

    // No done: watchdog fires, pulse at 42.
    sb.push_back('{3, 42, 0});
    run(0, rng(0, 0), '0, '0, '0, '0, 48);
    check("tmo_hi", hi_v, 0);
    check("tmo_busy", busy_v, rng(1, 41));

    // Abort at 10, stale done at 20 ignored.
    run(0, rng(0, 0), rng(20, 20), '0, rng(10, 10), '0, 25);
    check("abort_hi", hi_v, 0);
    check("abort_busy", busy_v, rng(1, 10));

    // Mult ignores divby0; done at 6 -> commit 7, last 5.
    sb.push_back('{1, 7, 5});
    run(0, rng(0, 0), rng(6, 6), rng(4, 4), '0, '0, 10);
    check("mult_dz_hi", hi_v, rng(7, 7));

    // Stall while rd_hilo held from 2, done at 8.
    sb.push_back('{1, 9, 7});
    run(0, rng(0, 0), rng(8, 8), '0, '0, rng(2, 20), 12);
    check("stall", stall_v, rng(2, 9));

    // req held through COMMIT: accepted again in the following IDLE.
    sb.push_back('{1, 4, 2});
    sb.push_back('{1, 10, 3});
    run(0, rng(0, 6), rng(3, 3) | rng(9, 9), '0, '0, '0, 14);
    check("b2b_ack", ack_v, rng(1, 1) | rng(6, 6));
    check("b2b_busy", busy_v, rng(1, 4) | rng(6, 10));

    // Async reset mid-WAIT, between edges.
    run(0, rng(0, 0), '0, '0, '0, '0, 5);
    rd_hilo = 1;
    #1;
    check("pre_rst_stall", {busy, stall}, 2'b11);
    check("pre_rst_last", last_cycles, 3);
    reset = 1;
    #1;
    check("arst_busy_start_stall", {busy, md_start, stall}, 3'b000);
    check("arst_last", last_cycles, 0);
    #1;
    reset   = 0;
    rd_hilo = 0;
    sb.push_back('{1, 4, 2});
    run(0, rng(0, 0), rng(3, 3), '0, '0, '0, 6);
    check("post_rst_ack", ack_v, rng(1, 1));
    check("post_rst_hi", hi_v, rng(4, 4));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
